instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the single-issue MIPS core. It owns the program counter and drives the word address into the combinational instruction memory. It registers each returned instruction together with its PC into a one-entry fetch register, which it offers to decode over a valid/ready handshake. It also accepts PC redirects from decode for branches and jumps.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- imem_addr  out  32  word index into instruction memory: {2'b00, pc[31:2]}. Combinational from the PC register.
- imem_instr  in  32  instruction word at imem_addr, valid in the same cycle (combinational memory).
- if_valid  out  1  fetch register holds an instruction for decode.
- if_instr  out  32  registered instruction.
- if_pc  out  32  byte PC of if_instr.
- id_ready  in  1  decode accepts if_instr this cycle.
- redirect_valid  in  1  one-cycle pulse: load redirect_pc.
- redirect_pc  in  32  branch/jump target, byte address.

## Operation
- State machine: BOOT -> RUN.
  - BOOT lasts exactly one cycle after reset release.
  - RUN persists until the next reset.
- Registers:
  - pc: next byte address to fetch.
  - if_valid, if_instr, if_pc: the fetch register.
- Accept condition: the fetch register is accepted when `id_ready && if_valid`.
- Load condition: load = state==RUN && (!if_valid || id_ready).
  - On load: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+4.
- Stall: if_valid=1 && id_ready=0. if_instr, if_pc and pc all hold, and imem_addr stays constant.
- PC arithmetic: 32-bit modular. 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect:
  - Takes priority over a stall.
  - Implies decode consumed the current fetch register entry.
  - redirect_pc[1:0] is ignored and forced to 0.
- Redirect without delay slot: pc<=redirect_pc and if_valid<=0 (flush). The next valid instruction is the one from redirect_pc.
- Redirect during BOOT: pc<=redirect_pc; if_valid stays 0.
- Reset mid-operation: all state returns to reset values in the cycle rst_n is sampled low. Any in-flight entry is discarded.

## Timing
- Reset values:
  - state=BOOT, pc=RESET_PC.
  - imem_addr=RESET_PC>>2.
  - if_valid=0, if_instr=32'h0000_0000 (NOP), if_pc=RESET_PC.
- First valid instruction: if_valid rises 2 cycles after rst_n goes high (1 BOOT cycle + 1 load cycle).
- Steady state: one instruction per cycle while id_ready=1. Latency from pc to if_instr is 1 cycle.
- Redirect asserted in cycle N:
  - imem_addr shows the target in N+1.
  - The target instruction is valid in N+2.
  - Without the delay slot there is 1 bubble.
- Simultaneous redirect_valid with id_ready=0: the redirect wins and the held entry is dropped or replaced (see Configuration).

## Configuration
- Macro: FETCH_DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - On redirect, the instruction at the current pc (the delay slot) is loaded into the fetch register as a normal load: if_instr<=imem_instr, if_pc<=pc, if_valid<=1.
  - Then pc<=redirect_pc. No bubble.
  - In BOOT the delay-slot capture is suppressed.
- Undefined: flush behaviour as in Operation, with a 1-cycle bubble per redirect.

## Structure
- Package instr_fetch_pkg holds:
  - INSTR_W=32 and ADDR_W=32.
  - NOP_INSTR=32'h0000_0000.
  - Default RESET_PC.
  - The state enum {BOOT, RUN}.
- Sub-module pc_next: purely combinational. Selects among hold / pc+4 / {redirect_pc[31:2],2'b00}. The top module keeps the registers and the handshake.

## Test plan
- Reset, then memory words 0..2 = 32'h2003AAAA, 32'h20245555, 32'h00400820, with id_ready=1:
  - if_valid rises 2 cycles after reset release.
  - if_instr/if_pc sequence is 2003AAAA/0, 20245555/4, 00400820/8.
  - imem_addr counts 0,1,2,3.
- Stall: id_ready=0 for 3 cycles while if_pc=4. if_instr stays 20245555, imem_addr stays 2 and if_valid stays 1. Resuming gives if_pc=8 next.
- Redirect to 32'h0000_0041 while if_pc=4:
  - imem_addr=16 the next cycle.
  - Without FETCH_DELAY_SLOT_EN: one cycle with if_valid=0, then if_pc=32'h40.
  - With FETCH_DELAY_SLOT_EN: if_pc=8 (delay slot), then 32'h40.
- Redirect while id_ready=0: the redirect is honoured and the stalled entry is not re-presented.
- Wrap: redirect to 32'hFFFF_FFFC. if_pc goes FFFF_FFFC, then 0000_0000.
- Reset asserted mid-stream at if_pc=8: next cycle if_valid=0, if_instr=0, imem_addr=0. Restart matches the first scenario.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [0:0] {
      BOOT,
      RUN
   } fetch_state_e;

   typedef enum logic [1:0] {
      SEL_HOLD,
      SEL_INC,
      SEL_REDIRECT
   } pc_sel_e;

   // Byte address forced onto a word boundary.
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: hold, sequential +4 (modular), or word-aligned redirect target.
module pc_next
   import instr_fetch_pkg::*;
(
   input  logic [ADDR_W-1:0] pc,
   input  logic              advance,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] next_pc
);

   pc_sel_e sel;

   always_comb begin
      sel = SEL_HOLD;
      if (redirect_valid) begin
         sel = SEL_REDIRECT;
      end else if (advance) begin
         sel = SEL_INC;
      end
   end

   always_comb begin
      next_pc = pc;
      unique case (sel)
         SEL_HOLD:     next_pc = pc;
         SEL_INC:      next_pc = pc + 32'd4;
         SEL_REDIRECT: next_pc = word_align(redirect_pc);
         default:      next_pc = pc;
      endcase
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, one-entry fetch register with valid/ready to decode.
// Optional MIPS branch delay slot capture enabled by FETCH_DELAY_SLOT_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   input  logic               id_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc
);

   fetch_state_e       state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  next_pc;
   logic               if_valid_q;
   logic [INSTR_W-1:0] if_instr_q;
   logic [ADDR_W-1:0]  if_pc_q;
   logic               load;
   logic               capture;

   assign load = (state_q == RUN) && (!if_valid_q || id_ready);

`ifdef FETCH_DELAY_SLOT_EN
   // The delay-slot instruction is taken on a redirect even if decode is stalled.
   assign capture = (state_q == RUN) && (load || redirect_valid);
`else
   assign capture = load && !redirect_valid;
`endif

   pc_next u_pc_next (
      .pc             (pc_q),
      .advance        (load),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .next_pc        (next_pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= NOP_INSTR;
         if_pc_q    <= RESET_PC;
      end else begin
         pc_q <= next_pc;
         case (state_q)
            BOOT: begin
               state_q <= RUN;
            end
            RUN: begin
               if (capture) begin
                  if_valid_q <= 1'b1;
                  if_instr_q <= imem_instr;
                  if_pc_q    <= pc_q;
               end else if (redirect_valid) begin
                  if_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

   assign imem_addr = {2'b00, pc_q[ADDR_W-1:2]};
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch with a combinational memory model.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int checks = 0;
   int errors = 0;

   instr_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] idx);
      case (idx)
         32'd0:   return 32'h2003_AAAA;
         32'd1:   return 32'h2024_5555;
         32'd2:   return 32'h0040_0820;
         default: return {8'hE0, idx[23:0]};
      endcase
   endfunction

   always_comb imem_instr = mem_word(imem_addr);

   typedef struct {
      logic        rst_n;
      logic        rdy;
      logic        rv;
      logic [31:0] rpc;
      logic        e_valid;
      logic [31:0] e_instr;
      logic [31:0] e_pc;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                      input logic [31:0] ea);
      vec_t v;
      v = '{r, rdy, rv, rpc, ev, ei, ep, ea};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      int cyc;
      rst_n          = 1'b0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      // Each row: inputs applied before an edge, expected outputs just after it.
      add(0, 1, 0, 0,            0, 32'h0,         32'h0,         32'h0);
      add(0, 1, 0, 0,            0, 32'h0,         32'h0,         32'h0);
      add(1, 1, 0, 0,            0, 32'h0,         32'h0,         32'h0);
      add(1, 1, 0, 0,            1, 32'h2003_AAAA, 32'h0,         32'h1);
      add(1, 1, 0, 0,            1, 32'h2024_5555, 32'h4,         32'h2);
      add(1, 0, 0, 0,            1, 32'h2024_5555, 32'h4,         32'h2);
      add(1, 0, 0, 0,            1, 32'h2024_5555, 32'h4,         32'h2);
      add(1, 0, 0, 0,            1, 32'h2024_5555, 32'h4,         32'h2);
      add(1, 1, 0, 0,            1, 32'h0040_0820, 32'h8,         32'h3);
`ifdef FETCH_DELAY_SLOT_EN
      add(1, 1, 1, 32'h41,       1, 32'hE000_0003, 32'hC,         32'h10);
`else
      add(1, 1, 1, 32'h41,       0, 32'h0040_0820, 32'h8,         32'h10);
`endif
      add(1, 1, 0, 0,            1, 32'hE000_0010, 32'h40,        32'h11);
      add(1, 0, 0, 0,            1, 32'hE000_0010, 32'h40,        32'h11);
`ifdef FETCH_DELAY_SLOT_EN
      add(1, 0, 1, 32'hFFFF_FFFC, 1, 32'hE000_0011, 32'h44,       32'h3FFF_FFFF);
`else
      add(1, 0, 1, 32'hFFFF_FFFC, 0, 32'hE000_0010, 32'h40,       32'h3FFF_FFFF);
`endif
      add(1, 1, 0, 0,            1, 32'hE0FF_FFFF, 32'hFFFF_FFFC, 32'h0);
      add(1, 1, 0, 0,            1, 32'h2003_AAAA, 32'h0,         32'h1);
      add(1, 1, 0, 0,            1, 32'h2024_5555, 32'h4,         32'h2);
      add(1, 1, 0, 0,            1, 32'h0040_0820, 32'h8,         32'h3);
      add(0, 1, 0, 0,            0, 32'h0,         32'h0,         32'h0);
      add(1, 1, 0, 0,            0, 32'h0,         32'h0,         32'h0);
      add(1, 1, 0, 0,            1, 32'h2003_AAAA, 32'h0,         32'h1);
      add(1, 1, 0, 0,            1, 32'h2024_5555, 32'h4,         32'h2);
`ifdef FETCH_DELAY_SLOT_EN
      add(1, 1, 1, 32'h41,       1, 32'h0040_0820, 32'h8,         32'h10);
`else
      add(1, 1, 1, 32'h41,       0, 32'h2024_5555, 32'h4,         32'h10);
`endif
      add(1, 1, 0, 0,            1, 32'hE000_0010, 32'h40,        32'h11);
      add(0, 1, 0, 0,            0, 32'h0,         32'h0,         32'h0);
      // Redirect during the BOOT cycle: target taken, nothing captured.
      add(1, 1, 1, 32'h103,      0, 32'h0,         32'h0,         32'h40);
      add(1, 1, 0, 0,            1, 32'hE000_0040, 32'h100,       32'h41);

      foreach (vecs[i]) begin
         rst_n          = vecs[i].rst_n;
         id_ready       = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         @(posedge clk);
         #1;
         check($sformatf("row%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].e_valid});
         check($sformatf("row%0d if_instr", i), if_instr, vecs[i].e_instr);
         check($sformatf("row%0d if_pc", i), if_pc, vecs[i].e_pc);
         check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].e_addr);
      end

      // First-valid latency after reset release, with a bounded wait.
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      while (!if_valid && cyc < 10) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("first_valid_latency", cyc, 2);
      check("first_valid_instr", if_instr, 32'h2003_AAAA);

      // Redirect while stalled: the held entry must not reappear.
      @(posedge clk);
      #1;
      id_ready       = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
`ifdef FETCH_DELAY_SLOT_EN
      check("stall_redirect_ds_pc", if_pc, 32'h8);
`else
      check("stall_redirect_flush", {31'b0, if_valid}, 32'h0);
`endif
      @(posedge clk);
      #1;
      check("stall_redirect_target_pc", if_pc, 32'h200);
      check("stall_redirect_target_instr", if_instr, 32'hE000_0080);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
